mem_port_arb: RTL



---
 rtl/mem_port_pkg.sv | 18 +
 rtl/mem_port_rr_pick.sv | 32 +++
 rtl/mem_port_arb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the burst memory port arbiter.
// Channel FSM states and line-address extraction.
package mem_port_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_REQ  = 2'd1,
        CH_XFER = 2'd2
    } ch_state_t;

    function automatic logic [63:0] line_of(
        input logic [63:0] addr,
        input int          off
    );
        return addr >> off;
    endfunction

endpackage

// File: rtl/mem_port_rr_pick.sv
// Round-robin picker: first set request at or after the pointer,
// wrapping from N_REQ-1 back to 0.
module mem_port_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDXW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDXW-1:0]  idx
);

    int   j;
    logic hit;

    always_comb begin
        pick = '0;
        idx  = '0;
        hit  = 1'b0;
        j    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!hit && req[j]) begin
                hit     = 1'b1;
                pick[j] = 1'b1;
                idx     = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates N_REQ fetch controllers onto one burst memory port.
// Read and write channels run independent round-robin lock-until-done FSMs.
module mem_port_arb
    import mem_port_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_OFF   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            s_rd_req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_rd_addr,
    input  logic [N_REQ*16-1:0]         s_rd_len,
    output logic [N_REQ-1:0]            s_rd_gnt,
    output logic [DATA_WIDTH-1:0]       s_rd_data,
    output logic [N_REQ-1:0]            s_rd_valid,
    input  logic [N_REQ-1:0]            s_rd_ready,
    output logic [N_REQ-1:0]            s_rd_done,
    input  logic [N_REQ-1:0]            s_wr_req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [N_REQ*16-1:0]         s_wr_len,
    output logic [N_REQ-1:0]            s_wr_gnt,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_wr_data,
    input  logic [N_REQ-1:0]            s_wr_valid,
    input  logic [N_REQ-1:0]            s_wr_last,
    output logic [N_REQ-1:0]            s_wr_ready,
    output logic [N_REQ-1:0]            s_wr_done,
    output logic                        m_rd_req,
    output logic [ADDR_WIDTH-1:0]       m_rd_addr,
    output logic [15:0]                 m_rd_len,
    input  logic                        m_rd_gnt,
    input  logic [DATA_WIDTH-1:0]       m_rd_data,
    input  logic                        m_rd_valid,
    input  logic                        m_rd_done,
    output logic                        m_rd_ready,
    output logic                        m_wr_req,
    output logic [ADDR_WIDTH-1:0]       m_wr_addr,
    output logic [15:0]                 m_wr_len,
    input  logic                        m_wr_gnt,
    output logic [DATA_WIDTH-1:0]       m_wr_data,
    output logic                        m_wr_valid,
    output logic                        m_wr_last,
    input  logic                        m_wr_ready,
    input  logic                        m_wr_done
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ch_state_t             rd_st, rd_nx, wr_st, wr_nx;
    logic [IDXW-1:0]       rd_own, rd_ptr, rd_idx;
    logic [IDXW-1:0]       wr_own, wr_ptr, wr_idx;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [15:0]           rd_len_q, wr_len_q;
    logic [N_REQ-1:0]      rd_elig, rd_pick, wr_pick;
    logic                  rd_any, wr_any, rd_cpl, wr_cpl;

    logic [ADDR_WIDTH-1:0] rd_addr_a [N_REQ];
    logic [ADDR_WIDTH-1:0] wr_addr_a [N_REQ];
    logic [15:0]           rd_len_a  [N_REQ];
    logic [15:0]           wr_len_a  [N_REQ];
    logic [DATA_WIDTH-1:0] wr_data_a [N_REQ];

    // A fill may not pass a write-back of the same line, whether that
    // write-back is in flight or being picked this very cycle.
    for (genvar g = 0; g < N_REQ; g++) begin : g_sl
        logic haz_busy, haz_pick;
        assign rd_addr_a[g] = s_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_addr_a[g] = s_wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_len_a[g]  = s_rd_len[g*16 +: 16];
        assign wr_len_a[g]  = s_wr_len[g*16 +: 16];
        assign wr_data_a[g] = s_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign haz_busy = (wr_st != CH_IDLE) &&
            (line_of(64'(rd_addr_a[g]), LINE_OFF) ==
             line_of(64'(wr_addr_q), LINE_OFF));
        assign haz_pick = (wr_st == CH_IDLE) && wr_any &&
            (line_of(64'(rd_addr_a[g]), LINE_OFF) ==
             line_of(64'(wr_addr_a[wr_idx]), LINE_OFF));
        assign rd_elig[g] = s_rd_req[g] && !haz_busy && !haz_pick;
    end

    mem_port_rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_rd_pick (
        .req  (rd_elig),
        .ptr  (rd_ptr),
        .pick (rd_pick),
        .idx  (rd_idx)
    );

    mem_port_rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_wr_pick (
        .req  (s_wr_req),
        .ptr  (wr_ptr),
        .pick (wr_pick),
        .idx  (wr_idx)
    );

    assign rd_any    = |rd_pick;
    assign wr_any    = |wr_pick;
    assign s_rd_data = m_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st     <= CH_IDLE;
            rd_own    <= '0;
            rd_ptr    <= '0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
        end else begin
            rd_st <= rd_nx;
            if (rd_st == CH_IDLE && rd_any) begin
                rd_own    <= rd_idx;
                rd_addr_q <= rd_addr_a[rd_idx];
                rd_len_q  <= rd_len_a[rd_idx];
            end
            if (rd_cpl)
                rd_ptr <= (rd_own == IDXW'(N_REQ-1)) ? '0 : rd_own + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st     <= CH_IDLE;
            wr_own    <= '0;
            wr_ptr    <= '0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
        end else begin
            wr_st <= wr_nx;
            if (wr_st == CH_IDLE && wr_any) begin
                wr_own    <= wr_idx;
                wr_addr_q <= wr_addr_a[wr_idx];
                wr_len_q  <= wr_len_a[wr_idx];
            end
            if (wr_cpl)
                wr_ptr <= (wr_own == IDXW'(N_REQ-1)) ? '0 : wr_own + 1'b1;
        end
    end

    always_comb begin
        rd_nx      = rd_st;
        rd_cpl     = 1'b0;
        m_rd_req   = 1'b0;
        m_rd_addr  = '0;
        m_rd_len   = '0;
        m_rd_ready = 1'b0;
        s_rd_gnt   = '0;
        s_rd_valid = '0;
        s_rd_done  = '0;
        unique case (rd_st)
            CH_IDLE: if (rd_any) rd_nx = CH_REQ;
            CH_REQ: begin
                m_rd_req         = 1'b1;
                m_rd_addr        = rd_addr_q;
                m_rd_len         = rd_len_q;
                s_rd_gnt[rd_own] = m_rd_gnt;
                if (m_rd_gnt) rd_nx = CH_XFER;
            end
            CH_XFER: begin
                m_rd_ready         = s_rd_ready[rd_own];
                s_rd_valid[rd_own] = m_rd_valid;
                s_rd_done[rd_own]  = m_rd_done;
                if (m_rd_valid && s_rd_ready[rd_own] && m_rd_done) begin
                    rd_cpl = 1'b1;
                    rd_nx  = CH_IDLE;
                end
            end
            default: rd_nx = CH_IDLE;
        endcase
    end

    always_comb begin
        wr_nx      = wr_st;
        wr_cpl     = 1'b0;
        m_wr_req   = 1'b0;
        m_wr_addr  = '0;
        m_wr_len   = '0;
        m_wr_data  = '0;
        m_wr_valid = 1'b0;
        m_wr_last  = 1'b0;
        s_wr_gnt   = '0;
        s_wr_ready = '0;
        s_wr_done  = '0;
        unique case (wr_st)
            CH_IDLE: if (wr_any) wr_nx = CH_REQ;
            CH_REQ: begin
                m_wr_req         = 1'b1;
                m_wr_addr        = wr_addr_q;
                m_wr_len         = wr_len_q;
                s_wr_gnt[wr_own] = m_wr_gnt;
                if (m_wr_gnt) wr_nx = CH_XFER;
            end
            CH_XFER: begin
                m_wr_data          = wr_data_a[wr_own];
                m_wr_valid         = s_wr_valid[wr_own];
                m_wr_last          = s_wr_last[wr_own];
                s_wr_ready[wr_own] = m_wr_ready;
                s_wr_done[wr_own]  = m_wr_done;
                if (m_wr_done) begin
                    wr_cpl = 1'b1;
                    wr_nx  = CH_IDLE;
                end
            end
            default: wr_nx = CH_IDLE;
        endcase
    end

endmodule
